// File: rtl/cache_axi_bridge.sv
// Bridges the 2-way data cache refill and write-back ports onto an AXI3 master.
// One read and one write may be outstanding; refills to a line being written back wait for B.
module cache_axi_bridge #(
    parameter logic [3:0] RD_ID = 4'd1,
    parameter logic [3:0] WR_ID = 4'd1
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         rd_req,
    output logic         rd_rdy,
    input  logic [2:0]   rd_type,
    input  logic [31:0]  rd_addr,
    output logic         ret_valid,
    output logic         ret_last,
    output logic [31:0]  ret_data,
    input  logic         wr_req,
    output logic         wr_rdy,
    input  logic [2:0]   wr_type,
    input  logic [31:0]  wr_addr,
    input  logic [3:0]   wr_wstrb,
    input  logic [127:0] wr_data,
    output logic [3:0]   arid,
    output logic [31:0]  araddr,
    output logic [7:0]   arlen,
    output logic [2:0]   arsize,
    output logic [1:0]   arburst,
    output logic [1:0]   arlock,
    output logic [3:0]   arcache,
    output logic [2:0]   arprot,
    output logic         arvalid,
    input  logic         arready,
    input  logic [3:0]   rid,
    input  logic [31:0]  rdata,
    input  logic [1:0]   rresp,
    input  logic         rlast,
    input  logic         rvalid,
    output logic         rready,
    output logic [3:0]   awid,
    output logic [31:0]  awaddr,
    output logic [7:0]   awlen,
    output logic [2:0]   awsize,
    output logic [1:0]   awburst,
    output logic [1:0]   awlock,
    output logic [3:0]   awcache,
    output logic [2:0]   awprot,
    output logic         awvalid,
    input  logic         awready,
    output logic [3:0]   wid,
    output logic [31:0]  wdata,
    output logic [3:0]   wstrb,
    output logic         wlast,
    output logic         wvalid,
    input  logic         wready,
    input  logic [3:0]   bid,
    input  logic [1:0]   bresp,
    input  logic         bvalid,
    output logic         bready
);

    localparam logic [1:0] R_IDLE = 2'd0;
    localparam logic [1:0] R_AR   = 2'd1;
    localparam logic [1:0] R_DATA = 2'd2;

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_SEND = 2'd1;
    localparam logic [1:0] W_RESP = 2'd2;

    logic [1:0]   r_state;
    logic [31:0]  rd_addr_q;
    logic [2:0]   rd_type_q;

    logic [1:0]   w_state;
    logic [31:0]  wr_addr_q;
    logic [2:0]   wr_type_q;
    logic [3:0]   wr_wstrb_q;
    logic [127:0] wr_data_q;
    logic [1:0]   w_cnt;
    logic         aw_done;
    logic         w_done;

    logic         hazard;
    logic         aw_fin;
    logic         w_fin;
    logic         unused_bits;

    // Line requests are aligned to 16 bytes and burst four words; everything else is a single beat.
    function automatic logic [31:0] req_addr(input logic [2:0] t, input logic [31:0] a);
        return (t == 3'b100) ? {a[31:4], 4'b0000} : a;
    endfunction

    function automatic logic [7:0] req_len(input logic [2:0] t);
        return (t == 3'b100) ? 8'd3 : 8'd0;
    endfunction

    function automatic logic [2:0] req_size(input logic [2:0] t);
        return (t == 3'b010 || t == 3'b100) ? 3'd2 : {1'b0, t[1:0]};
    endfunction

    assign arid    = RD_ID;
    assign awid    = WR_ID;
    assign wid     = WR_ID;
    assign arburst = 2'b01;
    assign awburst = 2'b01;
    assign arlock  = 2'b00;
    assign awlock  = 2'b00;
    assign arcache = 4'h0;
    assign awcache = 4'h0;
    assign arprot  = 3'h0;
    assign awprot  = 3'h0;

    assign wr_rdy = (w_state == W_IDLE);

    // Block a refill whose line is in flight for write-back, or is being accepted for it right now.
    assign hazard = ((w_state != W_IDLE) && (rd_addr[31:4] == wr_addr_q[31:4]))
                  || (wr_req && wr_rdy && (rd_addr[31:4] == wr_addr[31:4]));

    assign rd_rdy = (r_state == R_IDLE) && !hazard;

    assign arvalid = (r_state == R_AR);
    assign araddr  = req_addr(rd_type_q, rd_addr_q);
    assign arlen   = req_len(rd_type_q);
    assign arsize  = req_size(rd_type_q);

    assign rready    = (r_state == R_DATA);
    assign ret_valid = rvalid && rready && (rid == RD_ID);
    assign ret_data  = rdata;
    assign ret_last  = rlast;

    assign awvalid = (w_state == W_SEND) && !aw_done;
    assign awaddr  = req_addr(wr_type_q, wr_addr_q);
    assign awlen   = req_len(wr_type_q);
    assign awsize  = req_size(wr_type_q);

    assign wvalid = (w_state == W_SEND) && !w_done;
    assign wdata  = wr_data_q[{w_cnt, 5'd0} +: 32];
    assign wstrb  = (wr_type_q == 3'b100) ? 4'hf : wr_wstrb_q;
    assign wlast  = ({6'd0, w_cnt} == awlen);

    assign bready = (w_state == W_RESP);

    assign aw_fin = aw_done || (awvalid && awready);
    assign w_fin  = w_done || (wvalid && wready && wlast);

    assign unused_bits = ^{rresp, bresp};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state   <= R_IDLE;
            rd_addr_q <= 32'd0;
            rd_type_q <= 3'd0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (rd_req && rd_rdy) begin
                        rd_addr_q <= rd_addr;
                        rd_type_q <= rd_type;
                        r_state   <= R_AR;
                    end
                end
                R_AR: begin
                    if (arready) r_state <= R_DATA;
                end
                R_DATA: begin
                    if (ret_valid && rlast) r_state <= R_IDLE;
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    // AW and W retire independently; the response phase starts once both have finished.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            w_state    <= W_IDLE;
            wr_addr_q  <= 32'd0;
            wr_type_q  <= 3'd0;
            wr_wstrb_q <= 4'd0;
            wr_data_q  <= 128'd0;
            w_cnt      <= 2'd0;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (wr_req) begin
                        wr_addr_q  <= wr_addr;
                        wr_type_q  <= wr_type;
                        wr_wstrb_q <= wr_wstrb;
                        wr_data_q  <= wr_data;
                        w_cnt      <= 2'd0;
                        aw_done    <= 1'b0;
                        w_done     <= 1'b0;
                        w_state    <= W_SEND;
                    end
                end
                W_SEND: begin
                    if (awvalid && awready) aw_done <= 1'b1;
                    if (wvalid && wready) begin
                        w_cnt <= w_cnt + 2'd1;
                        if (wlast) w_done <= 1'b1;
                    end
                    if (aw_fin && w_fin) w_state <= W_RESP;
                end
                W_RESP: begin
                    if (bvalid && (bid == WR_ID)) w_state <= W_IDLE;
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_axi_bridge.sv
// Directed bench for cache_axi_bridge: refill, write-back, hazard, concurrency, ID filter, async reset.
module tb_cache_axi_bridge;

    logic         clk = 1'b0;
    logic         resetn;
    logic         rd_req, rd_rdy;
    logic [2:0]   rd_type;
    logic [31:0]  rd_addr;
    logic         ret_valid, ret_last;
    logic [31:0]  ret_data;
    logic         wr_req, wr_rdy;
    logic [2:0]   wr_type;
    logic [31:0]  wr_addr;
    logic [3:0]   wr_wstrb;
    logic [127:0] wr_data;
    logic [3:0]   arid, awid, wid;
    logic [31:0]  araddr, awaddr;
    logic [7:0]   arlen, awlen;
    logic [2:0]   arsize, awsize, arprot, awprot;
    logic [1:0]   arburst, awburst, arlock, awlock;
    logic [3:0]   arcache, awcache;
    logic         arvalid, arready;
    logic [3:0]   rid;
    logic [31:0]  rdata;
    logic [1:0]   rresp;
    logic         rlast, rvalid, rready;
    logic         awvalid, awready;
    logic [31:0]  wdata;
    logic [3:0]   wstrb;
    logic         wlast, wvalid, wready;
    logic [3:0]   bid;
    logic [1:0]   bresp;
    logic         bvalid, bready;

    int total_checks = 0;
    int bad_checks   = 0;

    logic       wready_pat [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [31:0] wdata_exp [5] = '{32'h11, 32'h22, 32'h22, 32'h33, 32'h44};
    logic       wlast_exp  [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    always #5 clk = ~clk;

    cache_axi_bridge #(.RD_ID(4'd1), .WR_ID(4'd1)) dut (
        .clk(clk), .resetn(resetn),
        .rd_req(rd_req), .rd_rdy(rd_rdy), .rd_type(rd_type), .rd_addr(rd_addr),
        .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data),
        .wr_req(wr_req), .wr_rdy(wr_rdy), .wr_type(wr_type), .wr_addr(wr_addr),
        .wr_wstrb(wr_wstrb), .wr_data(wr_data),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arlock(arlock), .arcache(arcache), .arprot(arprot),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
        .awburst(awburst), .awlock(awlock), .awcache(awcache), .awprot(awprot),
        .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    // Advance the given number of cycles and settle past the edge before new inputs are driven.
    task automatic applyStimulus(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        total_checks++;
        if (actual !== expected) begin
            bad_checks++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
        end
    endtask

    initial begin
        resetn = 1'b0;
        rd_req = 0; rd_type = 0; rd_addr = 0;
        wr_req = 0; wr_type = 0; wr_addr = 0; wr_wstrb = 0; wr_data = 0;
        arready = 0; rid = 0; rdata = 0; rresp = 0; rlast = 0; rvalid = 0;
        awready = 0; wready = 0; bid = 0; bresp = 0; bvalid = 0;

        #1;
        checkOutput("rst_arvalid", {31'd0, arvalid}, 32'd0);
        checkOutput("rst_rready", {31'd0, rready}, 32'd0);
        checkOutput("rst_awvalid", {31'd0, awvalid}, 32'd0);
        checkOutput("rst_wvalid", {31'd0, wvalid}, 32'd0);
        checkOutput("rst_bready", {31'd0, bready}, 32'd0);
        checkOutput("rst_ret_valid", {31'd0, ret_valid}, 32'd0);
        applyStimulus(2);
        resetn = 1'b1;
        #1;
        checkOutput("idle_rd_rdy", {31'd0, rd_rdy}, 32'd1);
        checkOutput("idle_wr_rdy", {31'd0, wr_rdy}, 32'd1);
        checkOutput("const_arburst", {30'd0, arburst}, 32'd1);
        checkOutput("const_awburst", {30'd0, awburst}, 32'd1);

        // Line refill
        rd_req = 1; rd_type = 3'b100; rd_addr = 32'h1C00_0234;
        #1 checkOutput("ref_rd_rdy", {31'd0, rd_rdy}, 32'd1);
        applyStimulus(1);
        rd_req = 0;
        for (int i = 0; i < 3; i++) begin
            arready = (i == 2);
            #1;
            checkOutput("ref_arvalid", {31'd0, arvalid}, 32'd1);
            checkOutput("ref_araddr", araddr, 32'h1C00_0230);
            checkOutput("ref_arlen", {24'd0, arlen}, 32'd3);
            checkOutput("ref_arsize", {29'd0, arsize}, 32'd2);
            checkOutput("ref_arid", {28'd0, arid}, 32'd1);
            applyStimulus(1);
        end
        arready = 0;
        #1;
        checkOutput("ref_arvalid_off", {31'd0, arvalid}, 32'd0);
        checkOutput("ref_rd_rdy_busy", {31'd0, rd_rdy}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            rvalid = 1; rid = 4'd1; rdata = 32'hA0 + i; rlast = (i == 3);
            #1;
            checkOutput("ref_rready", {31'd0, rready}, 32'd1);
            checkOutput("ref_ret_valid", {31'd0, ret_valid}, 32'd1);
            checkOutput("ref_ret_data", ret_data, 32'hA0 + i);
            checkOutput("ref_ret_last", {31'd0, ret_last}, (i == 3) ? 32'd1 : 32'd0);
            applyStimulus(1);
        end
        rvalid = 0; rlast = 0; rd_addr = 0; rd_type = 0;
        #1;
        checkOutput("ref_rd_rdy_after", {31'd0, rd_rdy}, 32'd1);
        checkOutput("ref_rready_after", {31'd0, rready}, 32'd0);

        // Line write-back with wready 1,0,1,1,1
        wr_req = 1; wr_type = 3'b100; wr_addr = 32'h0000_1230; wr_wstrb = 4'h3;
        wr_data = {32'h44, 32'h33, 32'h22, 32'h11};
        applyStimulus(1);
        wr_req = 0;
        for (int i = 0; i < 5; i++) begin
            awready = (i == 0); wready = wready_pat[i];
            #1;
            if (i == 0) begin
                checkOutput("wb_awvalid", {31'd0, awvalid}, 32'd1);
                checkOutput("wb_awaddr", awaddr, 32'h0000_1230);
                checkOutput("wb_awlen", {24'd0, awlen}, 32'd3);
                checkOutput("wb_awsize", {29'd0, awsize}, 32'd2);
            end else begin
                checkOutput("wb_awvalid_done", {31'd0, awvalid}, 32'd0);
            end
            checkOutput("wb_wvalid", {31'd0, wvalid}, 32'd1);
            checkOutput("wb_wdata", wdata, wdata_exp[i]);
            checkOutput("wb_wstrb", {28'd0, wstrb}, 32'hf);
            checkOutput("wb_wlast", {31'd0, wlast}, {31'd0, wlast_exp[i]});
            checkOutput("wb_wr_rdy_busy", {31'd0, wr_rdy}, 32'd0);
            applyStimulus(1);
        end
        awready = 0; wready = 0;
        #1;
        checkOutput("wb_wvalid_off", {31'd0, wvalid}, 32'd0);
        checkOutput("wb_bready", {31'd0, bready}, 32'd1);
        applyStimulus(1);
        checkOutput("wb_wr_rdy_wait", {31'd0, wr_rdy}, 32'd0);
        bvalid = 1; bid = 4'd1;
        applyStimulus(1);
        bvalid = 0;
        #1;
        checkOutput("wb_wr_rdy_after", {31'd0, wr_rdy}, 32'd1);
        checkOutput("wb_bready_off", {31'd0, bready}, 32'd0);

        // Word write, W completes before AW, foreign bid ignored
        wr_req = 1; wr_type = 3'b010; wr_addr = 32'h0000_4004; wr_wstrb = 4'b0110;
        wr_data = {96'd0, 32'hDEAD_BEEF};
        applyStimulus(1);
        wr_req = 0; wready = 1;
        #1;
        checkOutput("ww_awlen", {24'd0, awlen}, 32'd0);
        checkOutput("ww_awaddr", awaddr, 32'h0000_4004);
        checkOutput("ww_wlast", {31'd0, wlast}, 32'd1);
        checkOutput("ww_wstrb", {28'd0, wstrb}, 32'h6);
        checkOutput("ww_wdata", wdata, 32'hDEAD_BEEF);
        applyStimulus(1);
        wready = 0; awready = 1;
        #1;
        checkOutput("ww_wvalid_done", {31'd0, wvalid}, 32'd0);
        checkOutput("ww_awvalid_late", {31'd0, awvalid}, 32'd1);
        applyStimulus(1);
        awready = 0; bvalid = 1; bid = 4'd2;
        #1 checkOutput("ww_bready", {31'd0, bready}, 32'd1);
        applyStimulus(1);
        checkOutput("ww_bid_filter", {31'd0, wr_rdy}, 32'd0);
        bid = 4'd1;
        applyStimulus(1);
        bvalid = 0;
        #1 checkOutput("ww_wr_rdy_after", {31'd0, wr_rdy}, 32'd1);

        // Read-after-write hazard on line 0x1230
        wr_req = 1; wr_type = 3'b100; wr_addr = 32'h0000_1230; wr_wstrb = 4'hf;
        wr_data = {32'h4, 32'h3, 32'h2, 32'h1};
        rd_req = 1; rd_type = 3'b010; rd_addr = 32'h0000_1238;
        #1 checkOutput("hz_same_cycle", {31'd0, rd_rdy}, 32'd0);
        applyStimulus(1);
        wr_req = 0;
        for (int i = 0; i < 4; i++) begin
            awready = (i == 0); wready = 1;
            #1;
            checkOutput("hz_rd_rdy_send", {31'd0, rd_rdy}, 32'd0);
            checkOutput("hz_arvalid_send", {31'd0, arvalid}, 32'd0);
            applyStimulus(1);
        end
        awready = 0; wready = 0;
        for (int i = 0; i < 10; i++) begin
            #1;
            checkOutput("hz_rd_rdy_resp", {31'd0, rd_rdy}, 32'd0);
            checkOutput("hz_arvalid_resp", {31'd0, arvalid}, 32'd0);
            applyStimulus(1);
        end
        bvalid = 1; bid = 4'd1;
        #1 checkOutput("hz_rd_rdy_b", {31'd0, rd_rdy}, 32'd0);
        applyStimulus(1);
        bvalid = 0;
        #1;
        checkOutput("hz_rd_rdy_release", {31'd0, rd_rdy}, 32'd1);
        checkOutput("hz_arvalid_idle", {31'd0, arvalid}, 32'd0);
        applyStimulus(1);
        rd_req = 0; arready = 1;
        #1;
        checkOutput("hz_arvalid", {31'd0, arvalid}, 32'd1);
        checkOutput("hz_araddr", araddr, 32'h0000_1238);
        checkOutput("hz_arlen", {24'd0, arlen}, 32'd0);
        applyStimulus(1);
        arready = 0; rvalid = 1; rid = 4'd1; rdata = 32'hBEEF; rlast = 1;
        #1 checkOutput("hz_ret_valid", {31'd0, ret_valid}, 32'd1);
        applyStimulus(1);
        rvalid = 0; rlast = 0; rd_addr = 0;

        // Concurrent read and write, R beat with foreign rid
        wr_req = 1; wr_type = 3'b010; wr_addr = 32'h0000_2000; wr_wstrb = 4'hf;
        wr_data = {96'd0, 32'h55};
        rd_req = 1; rd_type = 3'b010; rd_addr = 32'h0000_3000;
        #1 checkOutput("cc_rd_rdy", {31'd0, rd_rdy}, 32'd1);
        applyStimulus(1);
        wr_req = 0; rd_req = 0;
        arready = 1; awready = 1; wready = 1;
        #1;
        checkOutput("cc_arvalid", {31'd0, arvalid}, 32'd1);
        checkOutput("cc_awvalid", {31'd0, awvalid}, 32'd1);
        checkOutput("cc_wvalid", {31'd0, wvalid}, 32'd1);
        checkOutput("cc_araddr", araddr, 32'h0000_3000);
        checkOutput("cc_awaddr", awaddr, 32'h0000_2000);
        applyStimulus(1);
        arready = 0; awready = 0; wready = 0;
        rvalid = 1; rid = 4'd2; rdata = 32'h66; rlast = 1;
        #1;
        checkOutput("cc_rready", {31'd0, rready}, 32'd1);
        checkOutput("cc_bready", {31'd0, bready}, 32'd1);
        checkOutput("cc_rid_filter", {31'd0, ret_valid}, 32'd0);
        applyStimulus(1);
        checkOutput("cc_rready_hold", {31'd0, rready}, 32'd1);
        rid = 4'd1; rdata = 32'h77; bvalid = 1; bid = 4'd1;
        #1;
        checkOutput("cc_ret_valid", {31'd0, ret_valid}, 32'd1);
        checkOutput("cc_ret_data", ret_data, 32'h77);
        applyStimulus(1);
        rvalid = 0; rlast = 0; bvalid = 0;
        #1;
        checkOutput("cc_rd_rdy_after", {31'd0, rd_rdy}, 32'd1);
        checkOutput("cc_wr_rdy_after", {31'd0, wr_rdy}, 32'd1);

        // Asynchronous reset during the second refill beat
        rd_req = 1; rd_type = 3'b100; rd_addr = 32'h0000_5000;
        wr_req = 1; wr_type = 3'b100; wr_addr = 32'h0000_6000;
        applyStimulus(1);
        rd_req = 0; wr_req = 0; arready = 1;
        applyStimulus(1);
        arready = 0; rvalid = 1; rid = 4'd1; rdata = 32'h1; rlast = 0;
        applyStimulus(1);
        rdata = 32'h2;
        #1;
        checkOutput("ar_rready_pre", {31'd0, rready}, 32'd1);
        checkOutput("ar_awvalid_pre", {31'd0, awvalid}, 32'd1);
        checkOutput("ar_wvalid_pre", {31'd0, wvalid}, 32'd1);
        resetn = 1'b0;
        #1;
        checkOutput("ar_rready", {31'd0, rready}, 32'd0);
        checkOutput("ar_arvalid", {31'd0, arvalid}, 32'd0);
        checkOutput("ar_awvalid", {31'd0, awvalid}, 32'd0);
        checkOutput("ar_wvalid", {31'd0, wvalid}, 32'd0);
        checkOutput("ar_bready", {31'd0, bready}, 32'd0);
        checkOutput("ar_ret_valid", {31'd0, ret_valid}, 32'd0);
        rvalid = 0;
        applyStimulus(2);
        resetn = 1'b1;
        #1;
        checkOutput("ar_rd_rdy", {31'd0, rd_rdy}, 32'd1);
        checkOutput("ar_wr_rdy", {31'd0, wr_rdy}, 32'd1);

        $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
        $finish;
    end

endmodule

// File: doc/cache_axi_bridge.md
Name: cache_axi_bridge

Overview:
Downstream neighbour of the 2-way data cache. It converts the cache's refill interface (rd_req/rd_rdy/ret_*) and its write-back interface (wr_req/wr_rdy/wr_*) into an AXI3 master port. It supports one outstanding read and one outstanding write. Reads that target the line currently being written back are held until that write completes, so refills never see stale memory.

Parameters:
RD_ID, 4'd1, AXI ID driven on arid; only R beats carrying this rid are consumed.
WR_ID, 4'd1, AXI ID driven on awid/wid; only B responses carrying this bid are consumed.

Ports:
clk  in  1  clock
resetn  in  1  asynchronous reset, active low
rd_req / rd_rdy  in / out  1 / 1  refill request handshake with the cache
rd_type / rd_addr  in  3 / 32  read request type (000 byte, 001 half, 010 word, 100 line) and start address
ret_valid / ret_last / ret_data  out  1 / 1 / 32  returned read beat
wr_req / wr_rdy  in / out  1 / 1  write-back request handshake
wr_type / wr_addr / wr_wstrb / wr_data  in  3 / 32 / 4 / 128  write-back request
arid / araddr / arlen / arsize  out  4 / 32 / 8 / 3  AR channel payload
arvalid / arready  out / in  1 / 1  AR handshake
rid / rdata / rresp / rlast  in  4 / 32 / 2 / 1  R channel payload (rresp ignored)
rvalid / rready  in / out  1 / 1  R handshake
awid / awaddr / awlen / awsize  out  4 / 32 / 8 / 3  AW channel payload
awvalid / awready  out / in  1 / 1  AW handshake
wid / wdata / wstrb / wlast  out  4 / 32 / 4 / 1  W channel payload
wvalid / wready  out / in  1 / 1  W handshake
bid / bresp  in  4 / 2  B channel payload (bresp ignored)
bvalid / bready  in / out  1 / 1  B handshake
arburst, awburst, arlock, awlock, arcache, awcache, arprot, awprot  out  2/2/2/2/4/4/3/3  constants 01/01/0/0/0/0/0/0

Behaviour:
- Reset: asynchronous, active low. Both FSMs go to IDLE; arvalid, rready, awvalid, wvalid, bready and ret_valid are 0. All latched registers clear.
- Read FSM has three states, R_IDLE -> R_AR -> R_DATA -> R_IDLE.
  - rd_rdy = (R_IDLE) & ~hazard.
  - On rd_req & rd_rdy, latch the address and type, then move to R_AR.
  - In R_AR, arvalid=1 with a stable payload; on arready, move to R_DATA.
- Read request payload:
  - Line request: araddr = {addr[31:4], 4'b0}, arlen = 3.
  - Other types: araddr = rd_addr, arlen = 0.
  - arsize = 2 for 010/100; otherwise {1'b0, rd_type[1:0]}.
- Read data return:
  - rready=1 only in R_DATA.
  - ret_valid = rvalid & rready & (rid==RD_ID), combinational with zero latency; ret_data = rdata, ret_last = rlast.
  - A beat with rlast returns the FSM to R_IDLE.
- Write FSM has three states, W_IDLE -> W_SEND -> W_RESP -> W_IDLE.
  - wr_rdy = (W_IDLE); it stays high continuously while idle.
  - On wr_req & wr_rdy, latch addr, type, wstrb and the 128-bit data; clear the beat counter and the aw_done/w_done flags; move to W_SEND.
- W_SEND behaviour:
  - awvalid = ~aw_done; aw_done sets on awready. awaddr/awlen/awsize follow the same rules as the read side.
  - wvalid = ~w_done; wdata = data[cnt*32 +: 32].
  - wstrb = 4'hf for a line request, else the latched wstrb.
  - wlast = (cnt == awlen). Each W handshake increments cnt (2 bits); the wlast handshake sets w_done.
  - AW and W proceed independently; W may complete before AW.
  - When both done (including the same cycle as the final handshake), move to W_RESP.
- W_RESP: bready=1; on bvalid & bid==WR_ID, return to W_IDLE.
- Read-after-write hazard:
  - hazard = (W != W_IDLE) & (rd_addr[31:4] == latched wr_addr[31:4]), OR (wr_req & wr_rdy & rd_addr[31:4] == wr_addr[31:4]).
  - While hazard is set, the read is not accepted; it is accepted in the cycle after B completes.
- Simultaneous events:
  - A read and a write to different lines may be accepted in the same cycle; they run concurrently.
  - A write may be accepted while a read is in R_DATA, and vice versa.
- All AXI payloads stay stable while valid is high and ready is low.
- Reset asserted mid-burst abandons the transaction immediately; no recovery is attempted.

Test Plan:
- Line refill: rd_req, type 100, addr 0x1C00_0234; arready after 2 cycles; 4 R beats 0xA0..0xA3 -> araddr 0x1C00_0230, arlen 3, arsize 2; ret_valid on 4 cycles, ret_last only with 0xA3; rd_rdy high again the next cycle.
- Line write-back: wr_req, addr 0x0000_1230, data {0x44,0x33,0x22,0x11}; wready toggling 1,0,1,1,1 -> W beats 0x11,0x22,0x33,0x44, wstrb 4'hf, wlast only on beat 4; wr_rdy=0 until bvalid, then 1.
- Word write: type 010, wstrb 4'b0110 -> awlen 0, a single beat with wlast=1 and wstrb 0110.
- Hazard: write to line 0x0000_1230 pending with bvalid delayed 10 cycles; rd_req to 0x0000_1238 -> rd_rdy=0 and no arvalid until the cycle after bvalid.
- Concurrency and ID filtering: a write to 0x2000 and a read to 0x3000 accepted in the same cycle -> both channels active; an R beat with rid != RD_ID -> no ret_valid.
- Async reset: resetn driven low during R_DATA beat 2 -> arvalid/rready/awvalid/wvalid/bready drop immediately; after release, rd_rdy=wr_rdy=1.
